// File: rtl/fetch_stage.sv
// Instruction fetch stage: IDLE -> REQ -> DONE handshake with instruction memory and PC commit.
// Optional fetch timeout enabled by defining FETCH_TIMEOUT_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC       = 32'h0000_3000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_en,
    input  logic        wb_en,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_busy,
    output logic        fetch_err,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_d;
    logic        imem_req_d;
    logic [31:0] imem_addr_d;
    logic [31:0] instr_d;
    logic        instr_valid_d;
    logic        misalign_err_d;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] timeout_cnt_q, timeout_cnt_d;
    logic       fetch_err_q, fetch_err_d;

    assign fetch_err = fetch_err_q;
`else
    assign fetch_err = 1'b0;
`endif

    // Adder wraps naturally modulo 2^32.
    assign pc_plus4   = pc + 32'd4;
    assign fetch_busy = (state_q == REQ);

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc;
        imem_req_d     = imem_req;
        imem_addr_d    = imem_addr;
        instr_d        = instr;
        instr_valid_d  = instr_valid;
        misalign_err_d = misalign_err;
`ifdef FETCH_TIMEOUT_EN
        timeout_cnt_d  = timeout_cnt_q;
        fetch_err_d    = fetch_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (if_en) begin
                    state_d       = REQ;
                    imem_req_d    = 1'b1;
                    imem_addr_d   = pc;
                    instr_valid_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
                    timeout_cnt_d = 8'd0;
`endif
                end
            end
            REQ: begin
                // Ack is checked first so a coincident timeout loses to real data.
                if (imem_ack) begin
                    state_d       = DONE;
                    imem_req_d    = 1'b0;
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (timeout_cnt_q == TIMEOUT_LAST) begin
                    state_d       = DONE;
                    imem_req_d    = 1'b0;
                    instr_d       = 32'h0000_0000;
                    instr_valid_d = 1'b1;
                    fetch_err_d   = 1'b1;
                end else begin
                    timeout_cnt_d = timeout_cnt_q + 8'd1;
                end
`endif
            end
            DONE: begin
                if (wb_en) begin
                    state_d = IDLE;
                    if (branch_taken) begin
                        pc_d = {branch_target[31:2], 2'b00};
                        if (branch_target[1:0] != 2'b00) begin
                            misalign_err_d = 1'b1;
                        end
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pc           <= RESET_PC;
            imem_req     <= 1'b0;
            imem_addr    <= RESET_PC;
            instr        <= 32'h0000_0000;
            instr_valid  <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc           <= pc_d;
            imem_req     <= imem_req_d;
            imem_addr    <= imem_addr_d;
            instr        <= instr_d;
            instr_valid  <= instr_valid_d;
            misalign_err <= misalign_err_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_cnt_q <= 8'd0;
            fetch_err_q   <= 1'b0;
        end else begin
            timeout_cnt_q <= timeout_cnt_d;
            fetch_err_q   <= fetch_err_d;
        end
    end
`endif

endmodule
